// File: rtl/fip_pkg.sv
// Shared types and constants for the Q16.16 fixed-point arbiter slice.
package fip_pkg;

   localparam int FIP_INT_BITS  = 16;
   localparam int FIP_FRAC_BITS = 16;

   localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] FIP_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } fip_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DIV,
      ST_FIX,
      ST_RESP
   } fip_arb_state_e;

endpackage

// File: rtl/fip_32_seq_div.sv
// Restoring magnitude divider, one quotient bit per cycle MSB first: (|x| << FRAC_BITS) / |y|.
// Only compiled when FIP_ARB_DIV_EN is defined.
`ifdef FIP_ARB_DIV_EN
module fip_32_seq_div #(
   parameter int FRAC_BITS = 16,
   localparam int DW = 32 + FRAC_BITS
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic [31:0]   x_i,
   input  logic [31:0]   y_i,
   output logic [DW-1:0] quot_o,
   output logic          done_o,
   output logic          dbz_o
);

   logic [DW-1:0] quot_q;
   logic [31:0]   rem_q;
   logic [31:0]   div_q;
   logic [5:0]    cnt_q;
   logic          busy_q;
   logic          dbz_q;

   logic [31:0]   magX;
   logic [31:0]   magY;
   logic [32:0]   remShift;
   logic          fits;
   logic [31:0]   remSub;

   // The remainder always stays below the divisor (at most 2^31), so the
   // subtraction can be done in 32 bits once the 33-bit compare says it fits.
   always_comb begin
      magX     = x_i[31] ? (~x_i + 32'd1) : x_i;
      magY     = y_i[31] ? (~y_i + 32'd1) : y_i;
      remShift = {rem_q, quot_q[DW-1]};
      fits     = (remShift >= {1'b0, div_q});
      remSub   = remShift[31:0] - div_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quot_q <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (start_i) begin
         quot_q <= {magX, {FRAC_BITS{1'b0}}};
         rem_q  <= '0;
         div_q  <= magY;
         cnt_q  <= '0;
         busy_q <= (magY != 32'd0);
         dbz_q  <= (magY == 32'd0);
      end else if (busy_q) begin
         quot_q <= {quot_q[DW-2:0], fits};
         rem_q  <= fits ? remSub : remShift[31:0];
         cnt_q  <= cnt_q + 6'd1;
         if (cnt_q == 6'(DW - 1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign quot_o = quot_q;
   assign done_o = busy_q && (cnt_q == 6'(DW - 1));
   assign dbz_o  = dbz_q;

endmodule
`endif

// File: rtl/fip_32_op_arbiter.sv
// Round-robin arbiter sharing one Q16.16 add/sub/mul/div unit among N_REQ requesters.
// Define FIP_ARB_DIV_EN to build the iterative divider; otherwise div returns ovf with add latency.
module fip_32_op_arbiter
   import fip_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int INT_BITS  = FIP_INT_BITS,
   parameter int FRAC_BITS = FIP_FRAC_BITS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [2*N_REQ-1:0]         req_op,
   input  logic [32*N_REQ-1:0]        req_x,
   input  logic [32*N_REQ-1:0]        req_y,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(N_REQ)-1:0]   resp_id,
   output logic [31:0]                resp_result,
   output logic                       resp_ovf,
   output logic                       resp_dbz
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int QW   = INT_BITS + FRAC_BITS;

   fip_arb_state_e state_q, state_d;
   logic [ID_W-1:0] rrPtr_q, rrPtr_d;
   fip_op_e         op_q, op_d;
   logic [31:0]     x_q, x_d;
   logic [31:0]     y_q, y_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [31:0]     result_q, result_d;
   logic            ovf_q, ovf_d;
   logic            dbz_q, dbz_d;

   logic            grantFound;
   logic [ID_W-1:0] grantIdx;
   logic [ID_W:0]   candSum;
   logic [ID_W-1:0] candIdx;
   fip_op_e         grantOp;
   logic [31:0]     grantX;
   logic [31:0]     grantY;

   logic [31:0]     sum;
   logic [31:0]     diff;
   logic [63:0]     prod;
   logic [63:0]     prodSh;
   logic [31:0]     execResult;
   logic            execOvf;

   // Search upward from rrPtr with wrap; the first valid requester wins.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      candSum    = '0;
      candIdx    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         candSum = {1'b0, rrPtr_q} + (ID_W+1)'(i);
         if (candSum >= (ID_W+1)'(N_REQ)) begin
            candSum = candSum - (ID_W+1)'(N_REQ);
         end
         candIdx = candSum[ID_W-1:0];
         if (!grantFound && req_valid[candIdx]) begin
            grantFound = 1'b1;
            grantIdx   = candIdx;
         end
      end
   end

   always_comb begin
      grantOp   = fip_op_e'(req_op[{grantIdx, 1'b0} +: 2]);
      grantX    = req_x[{grantIdx, 5'b0} +: 32];
      grantY    = req_y[{grantIdx, 5'b0} +: 32];
      req_ready = '0;
      if (state_q == ST_IDLE && grantFound) begin
         req_ready[grantIdx] = 1'b1;
      end
   end

   // Single-cycle datapath; the product is floored by the arithmetic shift.
   always_comb begin
      sum        = x_q + y_q;
      diff       = x_q - y_q;
      prod       = {{32{x_q[31]}}, x_q} * {{32{y_q[31]}}, y_q};
      prodSh     = $signed(prod) >>> FRAC_BITS;
      execResult = 32'd0;
      execOvf    = 1'b1;
      case (op_q)
         ADD: begin
            execResult = sum;
            execOvf    = (x_q[31] == y_q[31]) && (sum[31] != x_q[31]);
         end
         SUB: begin
            execResult = diff;
            execOvf    = (x_q[31] != y_q[31]) && (diff[31] != x_q[31]);
         end
         MUL: begin
            execResult = prodSh[31:0];
            execOvf    = !((&prodSh[63:QW-1]) || (~|prodSh[63:QW-1]));
         end
         default: begin
            execResult = 32'd0;
            execOvf    = 1'b1;
         end
      endcase
   end

`ifdef FIP_ARB_DIV_EN
   logic [QW+FRAC_BITS-1:0] divQuot;
   logic                    divDone;
   logic                    divDbz;
   logic                    divStart;
   logic                    fixNeg;
   logic [31:0]             fixResult;
   logic                    fixOvf;

   assign divStart = (state_q == ST_IDLE) && grantFound && (grantOp == DIV);

   fip_32_seq_div #(
      .FRAC_BITS (FRAC_BITS)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .start_i (divStart),
      .x_i     (grantX),
      .y_i     (grantY),
      .quot_o  (divQuot),
      .done_o  (divDone),
      .dbz_o   (divDbz)
   );

   // Negative quotients may reach 0x80000000 in magnitude; positive ones stop at 0x7FFFFFFF.
   always_comb begin
      fixNeg    = x_q[31] ^ y_q[31];
      fixResult = fixNeg ? (~divQuot[31:0] + 32'd1) : divQuot[31:0];
      fixOvf    = fixNeg ? (divQuot > (QW+FRAC_BITS)'(FIP_MIN))
                         : (divQuot > (QW+FRAC_BITS)'(FIP_MAX));
   end
`endif

   always_comb begin
      state_d  = state_q;
      rrPtr_d  = rrPtr_q;
      op_d     = op_q;
      x_d      = x_q;
      y_d      = y_q;
      id_d     = id_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grantFound) begin
               op_d    = grantOp;
               x_d     = grantX;
               y_d     = grantY;
               id_d    = grantIdx;
               rrPtr_d = (grantIdx == ID_W'(N_REQ - 1)) ? '0 : grantIdx + 1'b1;
`ifdef FIP_ARB_DIV_EN
               state_d = (grantOp == DIV) ? ST_DIV : ST_EXEC;
`else
               state_d = ST_EXEC;
`endif
            end
         end
         ST_EXEC: begin
            result_d = execResult;
            ovf_d    = execOvf;
            dbz_d    = 1'b0;
            state_d  = ST_RESP;
         end
`ifdef FIP_ARB_DIV_EN
         ST_DIV: begin
            if (divDbz) begin
               result_d = 32'd0;
               ovf_d    = 1'b0;
               dbz_d    = 1'b1;
               state_d  = ST_RESP;
            end else if (divDone) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            result_d = fixResult;
            ovf_d    = fixOvf;
            dbz_d    = 1'b0;
            state_d  = ST_RESP;
         end
`endif
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rrPtr_q  <= '0;
         op_q     <= ADD;
         x_q      <= '0;
         y_q      <= '0;
         id_q     <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rrPtr_q  <= rrPtr_d;
         op_q     <= op_d;
         x_q      <= x_d;
         y_q      <= y_d;
         id_q     <= id_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
      end
   end

   assign resp_valid  = (state_q == ST_RESP);
   assign resp_id     = id_q;
   assign resp_result = result_q;
   assign resp_ovf    = ovf_q;
   assign resp_dbz    = dbz_q;

endmodule

// File: tb/tb_fip_32_op_arbiter.sv
// Directed self-checking bench for fip_32_op_arbiter; div expectations follow FIP_ARB_DIV_EN.
module tb_fip_32_op_arbiter;
   import fip_pkg::*;

   localparam int N = 4;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [2*N-1:0]  req_op;
   logic [32*N-1:0] req_x;
   logic [32*N-1:0] req_y;
   logic            resp_valid;
   logic            resp_ready;
   logic [1:0]      resp_id;
   logic [31:0]     resp_result;
   logic            resp_ovf;
   logic            resp_dbz;

   int checks   = 0;
   int failures = 0;

   fip_32_op_arbiter #(.N_REQ(N)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_x       (req_x),
      .req_y       (req_y),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_ovf    (resp_ovf),
      .resp_dbz    (resp_dbz)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input fip_op_e op, input logic [31:0] x, input logic [31:0] y);
      req_op[2*idx +: 2] = op;
      req_x[32*idx +: 32] = x;
      req_y[32*idx +: 32] = y;
      req_valid[idx]      = 1'b1;
   endtask

   // One isolated transaction: accept, measure latency, check the response, handshake.
   task automatic runOp(input string tag, input int idx, input fip_op_e op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expRes, input logic expOvf, input logic expDbz,
                        input int expLat);
      int cyc;
      req_valid  = '0;
      resp_ready = 1'b0;
      applyStimulus(idx, op, x, y);
      #1;
      checkOutput({tag, "_ready"}, 64'(req_ready), 64'(1) << idx);
      tick();
      req_valid = '0;
      cyc = 1;
      while (!resp_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
      checkOutput({tag, "_id"}, 64'(resp_id), 64'(idx));
      checkOutput({tag, "_result"}, 64'(resp_result), 64'(expRes));
      checkOutput({tag, "_ovf"}, 64'(resp_ovf), 64'(expOvf));
      checkOutput({tag, "_dbz"}, 64'(resp_dbz), 64'(expDbz));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checkOutput({tag, "_released"}, 64'(resp_valid), 64'(0));
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int sawResp;
      clk        = 1'b0;
      reset      = 1'b1;
      req_valid  = '0;
      req_op     = '0;
      req_x      = '0;
      req_y      = '0;
      resp_ready = 1'b0;
      repeat (3) tick();

      checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
      checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
      checkOutput("rst_resp_id", 64'(resp_id), 64'(0));
      checkOutput("rst_resp_result", 64'(resp_result), 64'(0));
      reset = 1'b0;
      tick();

      runOp("mul_basic", 1, MUL, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 2);
      runOp("add_ovf",   0, ADD, 32'h7FFF_0000, 32'h0001_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
      runOp("sub_ovf",   2, SUB, 32'h8000_0000, 32'h0001_0000, 32'h7FFF_0000, 1'b1, 1'b0, 2);
      runOp("sub_neg",   3, SUB, 32'h0001_0000, 32'h0003_0000, 32'hFFFE_0000, 1'b0, 1'b0, 2);
      runOp("mul_ovf",   0, MUL, 32'h7FFF_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b1, 1'b0, 2);
      runOp("mul_neg",   2, MUL, 32'hFFFF_0000, 32'h0002_8000, 32'hFFFD_8000, 1'b0, 1'b0, 2);
      runOp("mul_floor", 3, MUL, 32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
`ifdef FIP_ARB_DIV_EN
      runOp("div_pos",   1, DIV, 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0, 50);
      runOp("div_neg",   2, DIV, 32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, 1'b0, 50);
      runOp("div_zero",  0, DIV, 32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 2);
      runOp("div_ovf",   3, DIV, 32'h7FFF_0000, 32'h0000_8000, 32'hFFFE_0000, 1'b1, 1'b0, 50);
`else
      runOp("div_off",   1, DIV, 32'h0003_0000, 32'h0002_0000, 32'h0000_0000, 1'b1, 1'b0, 2);
`endif

      // Abort an in-flight request with reset; no response may follow.
      applyStimulus(2, DIV, 32'h0003_0000, 32'h0002_0000);
      #1;
      checkOutput("abort_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
`ifdef FIP_ARB_DIV_EN
      repeat (19) tick();
`endif
      reset = 1'b1;
      #2;
      checkOutput("abort_resp_valid", 64'(resp_valid), 64'(0));
      checkOutput("abort_resp_id", 64'(resp_id), 64'(0));
      checkOutput("abort_resp_result", 64'(resp_result), 64'(0));
      checkOutput("abort_resp_ovf", 64'(resp_ovf), 64'(0));
      checkOutput("abort_resp_dbz", 64'(resp_dbz), 64'(0));
      checkOutput("abort_req_ready", 64'(req_ready), 64'(0));
      tick();
      reset = 1'b0;
      sawResp = 0;
      repeat (60) begin
         tick();
         if (resp_valid) sawResp = 1;
      end
      checkOutput("abort_no_resp", 64'(sawResp), 64'(0));

      // All four requesters contend continuously with ADD x=i.0 + 1.0.
      for (int i = 0; i < N; i++) begin
         applyStimulus(i, ADD, 32'(i) << 16, 32'h0001_0000);
      end
      resp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc = 0;
         while (!resp_valid && cyc < 10) begin
            tick();
            cyc++;
         end
         checkOutput($sformatf("rr%0d_valid", k), 64'(resp_valid), 64'(1));
         checkOutput($sformatf("rr%0d_id", k), 64'(resp_id), 64'(k % N));
         checkOutput($sformatf("rr%0d_result", k), 64'(resp_result), 64'(((k % N) + 1) << 16));
         tick();
      end

      // Stall the consumer; the requester-1 response must hold and nobody gets ready.
      resp_ready = 1'b0;
      cyc = 0;
      while (!resp_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      checkOutput("stall_valid", 64'(resp_valid), 64'(1));
      for (int s = 0; s < 10; s++) begin
         tick();
         checkOutput($sformatf("stall%0d_valid", s), 64'(resp_valid), 64'(1));
         checkOutput($sformatf("stall%0d_id", s), 64'(resp_id), 64'(1));
         checkOutput($sformatf("stall%0d_result", s), 64'(resp_result), 64'h0002_0000);
         checkOutput($sformatf("stall%0d_req_ready", s), 64'(req_ready), 64'(0));
      end
      resp_ready = 1'b1;
      tick();
      checkOutput("held_req_grant", 64'(req_ready), 64'h4);
      req_valid  = '0;
      resp_ready = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
